// File: rtl/seq_restoring_divider.sv
// ============================================================================
// seq_restoring_divider
//
// Unsigned radix-2 restoring divider producing one quotient bit per clock.
// Each step shifts the next dividend bit into the partial remainder and
// trial-subtracts the divisor as a + ~b + 1. The carry out of that sum is the
// inverted borrow: carry=1 keeps the difference, carry=0 restores the
// shifted remainder. A start/busy/done handshake connects the divider to the
// multiplier/divider top-level controller.
//
// Parameters
//   WIDTH        operand, quotient and remainder width in bits (>= 2)
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous active-high reset, aborts any operation
//   start        request, sampled only while busy is low
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while the iteration is running
//   done         one-cycle pulse, results valid in that cycle
//   quotient     result, held until the next accepted start completes
//   remainder    result, held until the next accepted start completes
//   div_by_zero  set together with done when the divisor was zero
// ============================================================================
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sub_a;
    logic [WIDTH:0]   sub_bn;
    logic [WIDTH+1:0] sum_ext;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // The top bit of the stored partial remainder is always zero: a kept
    // difference is smaller than the divisor and a restored value was
    // already smaller than the divisor, so it never feeds the next shift.
    logic unused_r_top;
    assign unused_r_top = r[WIDTH];

    // Handshake outputs decode directly from the state register so they
    // fall to zero in the same cycle that reset takes effect.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // One restoring step: shift the next dividend bit into the remainder,
    // add the inverted divisor plus one, and use the carry out as "no borrow".
    // On a borrow the shifted remainder is restored and a 0 quotient bit
    // enters; otherwise the difference is kept and a 1 enters.
    always_comb begin
        sub_a     = {r[WIDTH-1:0], q[WIDTH-1]};
        sub_bn    = ~{1'b0, dvsr};
        sum_ext   = {1'b0, sub_a} + {1'b0, sub_bn} + {{(WIDTH+1){1'b0}}, 1'b1};
        trial     = sum_ext[WIDTH:0];
        no_borrow = sum_ext[WIDTH+1];
        r_next    = no_borrow ? trial : sub_a;
        q_next    = {q[WIDTH-2:0], no_borrow};
    end

    // Control and datapath registers. A start is honoured in IDLE and in the
    // DONE cycle, so back-to-back operations lose no cycle. A zero divisor
    // bypasses the iteration and reports all-ones with the dividend as the
    // remainder. The visible results move only on the final step or on a
    // divide-by-zero accept, so a running operation never disturbs them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            dvsr  <= divisor;
                            r     <= '0;
                            q     <= dividend;
                            count <= CW'(WIDTH - 1);
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r <= r_next;
                    q <= q_next;
                    if (count == '0) begin
                        quotient    <= q_next;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider. It drives one 8-bit instance
// through directed cases and one 4-bit instance through every operand pair.
// Expected quotient, remainder, flag and completion edge are computed from
// integer division when a start is accepted, queued, and compared when the
// instance raises done.
// ============================================================================
module tb_seq_restoring_divider;

    typedef struct {
        int q;
        int r;
        int dbz;
        int doneEdge;
        int a;
        int b;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       start8;
    logic [7:0] dividend8;
    logic [7:0] divisor8;
    logic       busy8;
    logic       done8;
    logic [7:0] quot8;
    logic [7:0] rem8;
    logic       dbz8;

    logic       start4;
    logic [3:0] dividend4;
    logic [3:0] divisor4;
    logic       busy4;
    logic       done4;
    logic [3:0] quot4;
    logic [3:0] rem4;
    logic       dbz4;

    int   compared   = 0;
    int   mismatched = 0;
    int   cycles     = 0;

    exp_t sb8[$];
    exp_t sb4[$];
    exp_t e8;
    exp_t e4;

    seq_restoring_divider #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (quot8),
        .remainder   (rem8),
        .div_by_zero (dbz8)
    );

    seq_restoring_divider #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .dividend    (dividend4),
        .divisor     (divisor4),
        .busy        (busy4),
        .done        (done4),
        .quotient    (quot4),
        .remainder   (rem4),
        .div_by_zero (dbz4)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to timestamp accepts and completions.
    always @(posedge clk) begin
        cycles <= cycles + 1;
    end

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Build the expected outcome for an accepted start and queue it.
    task automatic pushExpected(input int w, input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q        = (1 << w) - 1;
            e.r        = a;
            e.dbz      = 1;
            e.doneEdge = cycles;
        end else begin
            e.q        = a / b;
            e.r        = a % b;
            e.dbz      = 0;
            e.doneEdge = cycles + w;
        end
        if (w == 8) sb8.push_back(e);
        else        sb4.push_back(e);
    endtask

    // Present one start pulse; the instance is assumed idle or in DONE.
    task automatic startOp(input int w, input int a, input int b);
        @(negedge clk);
        if (w == 8) begin
            start8    = 1'b1;
            dividend8 = 8'(a);
            divisor8  = 8'(b);
        end else begin
            start4    = 1'b1;
            dividend4 = 4'(a);
            divisor4  = 4'(b);
        end
        @(posedge clk);
        #1;
        pushExpected(w, a, b);
        start8 = 1'b0;
        start4 = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been consumed.
    task automatic waitDone(input int w);
        int pending;
        pending = (w == 8) ? sb8.size() : sb4.size();
        for (int k = 0; k < 40 && pending != 0; k++) begin
            @(negedge clk);
            #2;
            pending = (w == 8) ? sb8.size() : sb4.size();
        end
        checkOutput("drain_queue", pending, 0);
        if (w == 8) sb8.delete();
        else        sb4.delete();
    endtask

    task automatic applyStimulus(input int w, input int a, input int b);
        startOp(w, a, b);
        waitDone(w);
    endtask

    // Result checker for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                checkOutput("done8_unexpected", 1, 0);
            end else begin
                e8 = sb8.pop_front();
                checkOutput("quotient8", quot8, e8.q);
                checkOutput("remainder8", rem8, e8.r);
                checkOutput("dbz8", dbz8, e8.dbz);
                checkOutput("latency8", cycles, e8.doneEdge);
            end
        end
    end

    // Result checker for the 4-bit instance, including the division identity.
    always @(negedge clk) begin
        if (!rst && done4) begin
            if (sb4.size() == 0) begin
                checkOutput("done4_unexpected", 1, 0);
            end else begin
                e4 = sb4.pop_front();
                checkOutput("quotient4", quot4, e4.q);
                checkOutput("remainder4", rem4, e4.r);
                checkOutput("dbz4", dbz4, e4.dbz);
                checkOutput("latency4", cycles, e4.doneEdge);
                if (e4.b != 0) begin
                    checkOutput("inv4_recompose", int'(quot4) * e4.b + int'(rem4), e4.a);
                    checkOutput("inv4_rem_lt_div", (int'(rem4) < e4.b) ? 1 : 0, 1);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start8    = 1'b0;
        dividend8 = '0;
        divisor8  = '0;
        start4    = 1'b0;
        dividend4 = '0;
        divisor4  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy8, 0);
        checkOutput("rst_done", done8, 0);
        checkOutput("rst_quotient", quot8, 0);
        checkOutput("rst_remainder", rem8, 0);
        checkOutput("rst_dbz", dbz8, 0);
        checkOutput("rst_quotient4", quot4, 0);
        rst = 1'b0;

        // 100 / 7: busy for eight cycles, done on the ninth
        startOp(8, 100, 7);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t1_busy", busy8, 1);
            checkOutput("t1_not_done", done8, 0);
        end
        @(negedge clk);
        checkOutput("t1_done", done8, 1);
        checkOutput("t1_busy_low", busy8, 0);
        waitDone(8);

        // Boundary operands
        applyStimulus(8, 255, 1);
        applyStimulus(8, 3, 200);
        applyStimulus(8, 200, 200);

        // Results hold while the next operation runs
        startOp(8, 255, 1);
        @(negedge clk);
        checkOutput("hold_quotient", quot8, 1);
        checkOutput("hold_remainder", rem8, 0);
        waitDone(8);

        // Divide by zero: done after one edge, busy never high
        startOp(8, 5, 0);
        @(negedge clk);
        checkOutput("dbz_busy", busy8, 0);
        checkOutput("dbz_done", done8, 1);
        waitDone(8);

        // Start held through RUN with new operands; accepted on the done cycle
        @(negedge clk);
        start8    = 1'b1;
        dividend8 = 8'd100;
        divisor8  = 8'd7;
        @(posedge clk);
        #1;
        pushExpected(8, 100, 7);
        dividend8 = 8'd50;
        divisor8  = 8'd3;
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!done8 && k < 20) begin
                checkOutput("t4_busy_hold", busy8, 1);
                @(negedge clk);
                k++;
            end
            checkOutput("t4_first_done", done8, 1);
        end
        @(posedge clk);
        #1;
        pushExpected(8, 50, 3);
        start8 = 1'b0;
        @(negedge clk);
        checkOutput("t4_busy_next", busy8, 1);
        waitDone(8);

        // Reset in the middle of an operation
        startOp(8, 200, 13);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb8.delete();
        @(negedge clk);
        checkOutput("mid_rst_busy", busy8, 0);
        checkOutput("mid_rst_done", done8, 0);
        checkOutput("mid_rst_quotient", quot8, 0);
        checkOutput("mid_rst_remainder", rem8, 0);
        checkOutput("mid_rst_dbz", dbz8, 0);
        #1;
        rst = 1'b0;
        applyStimulus(8, 200, 13);

        // A handful of random 8-bit operations
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        // Every 4-bit operand pair
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(4, a, b);
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
